calc_seq_ctrl: RTL and testbench
================================

Name: calc_seq_ctrl

Overview:
- Sequencing controller for the one-digit calculator datapath (4-bit adder and subtractor).
- Debounces the 14 push switches and decodes key strokes.
- Steps a small FSM through operand-A entry, operator/operand-B entry and result display.
- Drives A_DATA/B_DATA into the adder and subtractor, captures SUM_DATA/SUB_DATA on '=', and presents a sign/magnitude value to the seven-segment driver.

Parameters:
- DEB_CYCLES, 50000, clock cycles between switch samples (1 ms at 50 MHz).
- DEB_W, 16, width of the sample-interval counter; DEB_CYCLES-1 must fit.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_X  in  1  asynchronous, active-low reset.
- PSW  in  14  push switches, 1 = pressed. [9:0] digit keys 0-9, [10] '+', [11] '-', [12] '=', [13] clear.
- SUM_DATA  in  6  A_DATA+B_DATA from the adder, unsigned.
- SUB_DATA  in  6  A_DATA-B_DATA from the subtractor, 6-bit two's complement.
- A_DATA  out  4  operand A register.
- B_DATA  out  4  operand B register.
- DISP_VAL  out  6  magnitude to display, 0..18.
- DISP_NEG  out  1  minus sign for the display.
- STATE_OUT  out  2  current FSM state code.
- KEY_STB  out  1  one-cycle pulse per accepted key; debug only.

Behaviour:
- Reset (RST_X=0, async): counter=0, sample regs=0, state=S_A, A=B=0, op=ADD, a_valid=b_valid=0, RES=0, NEG=0, all outputs 0. Release is synchronous to the next CLK edge.
- Sampling:
  - Free-running counter 0..DEB_CYCLES-1, wraps.
  - At wrap, PSW is sampled into s1; the previous s1 moves to s0.
  - A key is "stable-pressed" when s1[i]&s0[i].
  - A key event fires when a key becomes stable-pressed and was not stable-pressed at the previous sample.
  - Key latency: 2 samples after the press settles, plus 1 cycle. Holding a key yields exactly one event. Releasing yields nothing.
- Simultaneous events in one sample: exactly one key is accepted, by priority clear > '=' > '-' > '+' > lowest digit index. All other new presses in that sample are discarded, including when they are held.
- KEY_STB pulses for the single cycle the FSM consumes the event.
- FSM state codes: S_A=0, S_B=1, S_RES=2; code 3 is unused and recovers to S_A.
- S_A:
  - digit k: A=k, a_valid=1.
  - '+'/'-' with a_valid: op=ADD/SUB, b_valid=0, go to S_B.
  - '+'/'-' without a_valid: ignored.
  - '=': ignored.
- S_B:
  - digit k: B=k, b_valid=1.
  - '+'/'-': op is overwritten; B is kept.
  - '=' with b_valid: capture and go to S_RES.
  - '=' without b_valid: ignored.
- Capture on '=' (same edge as the state change; datapath is combinational, so no wait state):
  - ADD: RES=SUM_DATA, NEG=0.
  - SUB: NEG=SUB_DATA[5]; RES=NEG ? -SUB_DATA (6-bit two's negate) : SUB_DATA.
- S_RES:
  - digit k: A=k, B=0, a_valid=1, b_valid=0, go to S_A (new calculation).
  - operator and '=': ignored.
- Clear, in any state: same values as reset except the debounce registers and counter, which keep running.
- Display:
  - S_A: DISP_VAL={2'b0,A}, DISP_NEG=0.
  - S_B: shows B when b_valid, else A. DISP_NEG=0.
  - S_RES: DISP_VAL=RES, DISP_NEG=NEG.
  - All outputs are registered.
- Range: RES is 0..18 for ADD and 0..9 for SUB, so -0 never occurs (9-9 gives NEG=0). Digit input is never greater than 9.

Decomposition:
- Package calc_pkg holds:
  - state codes S_A/S_B/S_RES;
  - key indices KEY_PLUS=10, KEY_MINUS=11, KEY_EQ=12, KEY_CLR=13;
  - op encoding ADD=0/SUB=1.
- Sub-module calc_key_scan holds:
  - the sample counter, s0/s1, edge detect and priority encoder;
  - its outputs are key_valid and key_code[3:0] (0-13).
- calc_seq_ctrl holds the FSM, operand/result registers and the display mux.

Test Plan (DEB_CYCLES=4):
- Reset mid-entry: press 7, assert RST_X low for 1 cycle -> A_DATA=0, STATE_OUT=0, DISP_VAL=0 immediately (async).
- Press 7, '+', 8, '=' -> STATE_OUT=2, DISP_VAL=15, DISP_NEG=0, A_DATA=7, B_DATA=8.
- Press 3, '-', 9, '=' -> DISP_VAL=6, DISP_NEG=1. Then press 5 -> STATE_OUT=0, A_DATA=5, B_DATA=0, DISP_NEG=0.
- Hold digit 4 for 40 cycles, plus a 1-sample glitch on digit 2 -> exactly one KEY_STB, A_DATA=4.
- Press '=' in S_A, then '+' with no digit -> no state change, KEY_STB still pulses for each.
- In one sample, press 6 and clear together -> clear wins, A_DATA=0. Press 9, '+', 9, '=' -> DISP_VAL=18. Then clear -> STATE_OUT=0, all outputs 0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared encodings for the one-digit calculator sequencer: FSM state codes,
// key indices on the push-switch bus and the operator encoding.
package calc_pkg;

    localparam logic [1:0] S_A   = 2'd0;
    localparam logic [1:0] S_B   = 2'd1;
    localparam logic [1:0] S_RES = 2'd2;

    localparam logic [3:0] KEY_PLUS  = 4'd10;
    localparam logic [3:0] KEY_MINUS = 4'd11;
    localparam logic [3:0] KEY_EQ    = 4'd12;
    localparam logic [3:0] KEY_CLR   = 4'd13;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/calc_key_scan.sv
// Switch debouncer and key decoder: samples the 14 push switches once per
// DEB_CYCLES, detects newly stable presses and emits one prioritised key code.
module calc_key_scan
    import calc_pkg::*;
#(
    parameter int DEB_CYCLES = 50000,
    parameter int DEB_W      = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] psw,
    output logic        key_valid,
    output logic [3:0]  key_code
);

    logic [DEB_W-1:0] cnt;
    logic [13:0]      s0;
    logic [13:0]      s1;
    logic [13:0]      stable_prev;
    logic             samp_d;
    logic             wrap;
    logic [13:0]      new_press;

    assign wrap = (cnt == DEB_W'(DEB_CYCLES - 1));

    // Clear beats '=' beats '-' beats '+' beats the lowest-numbered digit.
    function automatic logic [3:0] prio_code(input logic [13:0] ev);
        logic [3:0] code;
        code = 4'd0;
        if (ev[KEY_CLR])        code = KEY_CLR;
        else if (ev[KEY_EQ])    code = KEY_EQ;
        else if (ev[KEY_MINUS]) code = KEY_MINUS;
        else if (ev[KEY_PLUS])  code = KEY_PLUS;
        else begin
            for (int i = 9; i >= 0; i--) begin
                if (ev[i]) code = 4'(i);
            end
        end
        return code;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            s0          <= '0;
            s1          <= '0;
            stable_prev <= '0;
            samp_d      <= 1'b0;
        end else begin
            samp_d <= wrap;
            if (wrap) begin
                cnt         <= '0;
                s1          <= psw;
                s0          <= s1;
                stable_prev <= s1 & s0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Edge detect is evaluated only in the cycle right after a sample, so each
    // new stable press yields a single-cycle event; losers of the priority
    // race are absorbed into stable_prev at the next sample and never fire.
    always_comb begin
        new_press = (s1 & s0) & ~stable_prev;
        key_valid = samp_d & (|new_press);
        key_code  = prio_code(new_press);
    end

endmodule

// File: rtl/calc_seq_ctrl.sv
// Sequencing controller for the one-digit calculator: operand entry FSM,
// result capture from the external adder/subtractor and display selection.
module calc_seq_ctrl
    import calc_pkg::*;
#(
    parameter int DEB_CYCLES = 50000,
    parameter int DEB_W      = 16
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic [13:0] PSW,
    input  logic [5:0]  SUM_DATA,
    input  logic [5:0]  SUB_DATA,
    output logic [3:0]  A_DATA,
    output logic [3:0]  B_DATA,
    output logic [5:0]  DISP_VAL,
    output logic        DISP_NEG,
    output logic [1:0]  STATE_OUT,
    output logic        KEY_STB
);

    logic       key_valid;
    logic [3:0] key_code;
    logic       op;
    logic       a_valid;
    logic       b_valid;
    logic [5:0] res;
    logic       neg;
    logic       is_digit;
    logic       is_op;

    calc_key_scan #(
        .DEB_CYCLES(DEB_CYCLES),
        .DEB_W     (DEB_W)
    ) u_key_scan (
        .clk      (CLK),
        .rst_n    (RST_X),
        .psw      (PSW),
        .key_valid(key_valid),
        .key_code (key_code)
    );

    function automatic logic [5:0] mag6(input logic [5:0] v);
        return v[5] ? (~v + 6'd1) : v;
    endfunction

    assign is_digit = (key_code <= 4'd9);
    assign is_op    = (key_code == KEY_PLUS) || (key_code == KEY_MINUS);

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            STATE_OUT <= S_A;
            A_DATA    <= '0;
            B_DATA    <= '0;
            op        <= OP_ADD;
            a_valid   <= 1'b0;
            b_valid   <= 1'b0;
            res       <= '0;
            neg       <= 1'b0;
            DISP_VAL  <= '0;
            DISP_NEG  <= 1'b0;
            KEY_STB   <= 1'b0;
        end else begin
            KEY_STB <= key_valid;

            case (STATE_OUT)
                S_B: begin
                    DISP_VAL <= b_valid ? {2'b00, B_DATA} : {2'b00, A_DATA};
                    DISP_NEG <= 1'b0;
                end
                S_RES: begin
                    DISP_VAL <= res;
                    DISP_NEG <= neg;
                end
                default: begin
                    DISP_VAL <= {2'b00, A_DATA};
                    DISP_NEG <= 1'b0;
                end
            endcase

            if (key_valid && key_code == KEY_CLR) begin
                STATE_OUT <= S_A;
                A_DATA    <= '0;
                B_DATA    <= '0;
                op        <= OP_ADD;
                a_valid   <= 1'b0;
                b_valid   <= 1'b0;
                res       <= '0;
                neg       <= 1'b0;
                DISP_VAL  <= '0;
                DISP_NEG  <= 1'b0;
            end else begin
                case (STATE_OUT)
                    S_A: begin
                        if (key_valid && is_digit) begin
                            A_DATA  <= key_code;
                            a_valid <= 1'b1;
                        end else if (key_valid && is_op && a_valid) begin
                            op        <= (key_code == KEY_MINUS) ? OP_SUB : OP_ADD;
                            b_valid   <= 1'b0;
                            STATE_OUT <= S_B;
                        end
                    end
                    S_B: begin
                        if (key_valid && is_digit) begin
                            B_DATA  <= key_code;
                            b_valid <= 1'b1;
                        end else if (key_valid && is_op) begin
                            op <= (key_code == KEY_MINUS) ? OP_SUB : OP_ADD;
                        end else if (key_valid && key_code == KEY_EQ && b_valid) begin
                            // Datapath is combinational, so results are valid now.
                            if (op == OP_SUB) begin
                                neg <= SUB_DATA[5];
                                res <= mag6(SUB_DATA);
                            end else begin
                                neg <= 1'b0;
                                res <= SUM_DATA;
                            end
                            STATE_OUT <= S_RES;
                        end
                    end
                    S_RES: begin
                        if (key_valid && is_digit) begin
                            A_DATA    <= key_code;
                            B_DATA    <= '0;
                            a_valid   <= 1'b1;
                            b_valid   <= 1'b0;
                            STATE_OUT <= S_A;
                        end
                    end
                    default: STATE_OUT <= S_A;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Scoreboard bench for calc_seq_ctrl with a fast debounce interval.
module tb_calc_seq_ctrl;

    typedef struct packed {
        logic [1:0] st;
        logic [3:0] a;
        logic [3:0] b;
        logic [5:0] val;
        logic       neg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] psw = '0;
    logic [5:0]  sum_data;
    logic [5:0]  sub_data;
    logic [3:0]  a_data;
    logic [3:0]  b_data;
    logic [5:0]  disp_val;
    logic        disp_neg;
    logic [1:0]  state_out;
    logic        key_stb;

    int   checks = 0;
    int   errors = 0;
    int   stb_cnt = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    assign sum_data = {2'b00, a_data} + {2'b00, b_data};
    assign sub_data = {2'b00, a_data} - {2'b00, b_data};

    calc_seq_ctrl #(.DEB_CYCLES(4), .DEB_W(16)) dut (
        .CLK      (clk),
        .RST_X    (rst_n),
        .PSW      (psw),
        .SUM_DATA (sum_data),
        .SUB_DATA (sub_data),
        .A_DATA   (a_data),
        .B_DATA   (b_data),
        .DISP_VAL (disp_val),
        .DISP_NEG (disp_neg),
        .STATE_OUT(state_out),
        .KEY_STB  (key_stb)
    );

    always @(negedge clk) if (rst_n && key_stb) stb_cnt++;

    function automatic exp_t mk(input int st, input int a, input int b, input int val, input int neg);
        exp_t e;
        e.st = 2'(st); e.a = 4'(a); e.b = 4'(b); e.val = 6'(val); e.neg = 1'(neg);
        return e;
    endfunction

    function automatic logic [13:0] km(input int k);
        return 14'(1) << k;
    endfunction

    function automatic exp_t observe();
        return {state_out, a_data, b_data, disp_val, disp_neg};
    endfunction

    // Hold the keys long enough for two samples, then release and let it settle.
    task automatic press(input logic [13:0] mask, input exp_t e, output bit got);
        got = 1'b0;
        sb_q.push_back(e);
        psw = mask;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 16) psw = '0;
            if (key_stb) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        exp_t o, e;
        bit got;
        o = observe();
        checks++;
        if (o !== 17'd0 || key_stb !== 1'b0) begin
            errors++;
            $display("FAIL reset_init got=%h stb=%b want=0 stb=0", o, key_stb);
        end
        @(negedge clk); rst_n = 1'b1;
        press(km(7), mk(0, 7, 0, 7, 0), got);
        e = sb_q.pop_front(); o = observe();
        checks++;
        if (!got || o !== e) begin
            errors++;
            $display("FAIL reset_press7 got=%h stb=%b want=%h stb=1", o, got, e);
        end
        @(negedge clk); rst_n = 1'b0;
        #1;
        checks++;
        if (a_data !== 4'd0 || state_out !== 2'd0 || disp_val !== 6'd0) begin
            errors++;
            $display("FAIL reset_async a=%0d st=%0d val=%0d want 0/0/0", a_data, state_out, disp_val);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_add();
        logic [13:0] k[4];
        exp_t x[4];
        exp_t o, e;
        bit got;
        k = '{km(7), km(10), km(8), km(12)};
        x = '{mk(0,7,0,7,0), mk(1,7,0,7,0), mk(1,7,8,8,0), mk(2,7,8,15,0)};
        for (int i = 0; i < 4; i++) begin
            press(k[i], x[i], got);
            e = sb_q.pop_front(); o = observe();
            checks++;
            if (!got || o !== e) begin
                errors++;
                $display("FAIL add_step%0d got=%h stb=%b want=%h stb=1", i, o, got, e);
            end
        end
    endtask

    task automatic test_sub();
        logic [13:0] k[5];
        exp_t x[5];
        exp_t o, e;
        bit got;
        k = '{km(3), km(11), km(9), km(12), km(5)};
        x = '{mk(0,3,0,3,0), mk(1,3,0,3,0), mk(1,3,9,9,0), mk(2,3,9,6,1), mk(0,5,0,5,0)};
        for (int i = 0; i < 5; i++) begin
            press(k[i], x[i], got);
            e = sb_q.pop_front(); o = observe();
            checks++;
            if (!got || o !== e) begin
                errors++;
                $display("FAIL sub_step%0d got=%h stb=%b want=%h stb=1", i, o, got, e);
            end
        end
    endtask

    task automatic test_hold_glitch();
        int   base;
        exp_t o, e;
        base = stb_cnt;
        sb_q.push_back(mk(0, 4, 0, 4, 0));
        psw = km(4);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 20) psw = km(4) | km(2);
            if (i == 24) psw = km(4);
        end
        psw = '0;
        repeat (24) @(negedge clk);
        checks++;
        if (stb_cnt - base !== 1) begin
            errors++;
            $display("FAIL hold_strobes got=%0d want=1", stb_cnt - base);
        end
        e = sb_q.pop_front(); o = observe();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL hold_value got=%h want=%h", o, e);
        end
    endtask

    task automatic test_ignored();
        logic [13:0] k[3];
        exp_t o, e;
        bit got;
        k = '{km(13), km(12), km(10)};
        for (int i = 0; i < 3; i++) begin
            press(k[i], mk(0, 0, 0, 0, 0), got);
            e = sb_q.pop_front(); o = observe();
            checks++;
            if (!got || o !== e) begin
                errors++;
                $display("FAIL ignored_step%0d got=%h stb=%b want=%h stb=1", i, o, got, e);
            end
        end
    endtask

    task automatic test_clear_priority();
        logic [13:0] k[7];
        exp_t x[7];
        exp_t o, e;
        bit got;
        k = '{km(3), km(6) | km(13), km(9), km(10), km(9), km(12), km(13)};
        x = '{mk(0,3,0,3,0), mk(0,0,0,0,0), mk(0,9,0,9,0), mk(1,9,0,9,0),
              mk(1,9,9,9,0), mk(2,9,9,18,0), mk(0,0,0,0,0)};
        for (int i = 0; i < 7; i++) begin
            press(k[i], x[i], got);
            e = sb_q.pop_front(); o = observe();
            checks++;
            if (!got || o !== e) begin
                errors++;
                $display("FAIL clrprio_step%0d got=%h stb=%b want=%h stb=1", i, o, got, e);
            end
        end
        checks++;
        if (key_stb !== 1'b0) begin
            errors++;
            $display("FAIL idle_stb got=%b want=0", key_stb);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_add();
        test_sub();
        test_hold_glitch();
        test_ignored();
        test_clear_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
